// File: rtl/mul16_seq.sv
// Sequential 16x16 shift-and-add multiplier around a single adder16bit.
// Optional signed mode is compiled in with MUL_SIGNED_EN.

module adder16bit (
   input  logic [15:0] A,
   input  logic [15:0] B,
   input  logic        C_in,
   output logic [15:0] S,
   output logic        C_out
);

   assign {C_out, S} = {1'b0, A} + {1'b0, B} + {16'h0, C_in};

endmodule

module mul16_seq #(
   parameter bit ZERO_SKIP = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] A,
   input  logic [15:0] B,
`ifdef MUL_SIGNED_EN
   input  logic        SIGNED,
`endif
   output logic        busy,
   output logic        done,
   output logic [31:0] P
);

`ifdef MUL_SIGNED_EN
   typedef enum logic [1:0] {
      S_IDLE, S_RUN, S_NEG, S_DONE
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE, S_RUN, S_DONE
   } state_t;
`endif

   state_t      state;
   state_t      state_n;
   logic [15:0] mcand;
   logic [15:0] acc_hi;
   logic [15:0] acc_lo;
   logic [3:0]  count;
   logic [15:0] add_b;
   logic [15:0] sum;
   logic        cout;
   logic        accept;
   logic        zero;
   logic [15:0] a_mag;
   logic [15:0] b_mag;
   logic [31:0] prod;
   logic        busy_n;

`ifdef MUL_SIGNED_EN
   logic        neg_q;
   logic        smode_q;
   logic        sign_n;
`endif

   assign prod  = {acc_hi, acc_lo};
   assign add_b = acc_lo[0] ? mcand : 16'h0;

   adder16bit u_add (
      .A     (acc_hi),
      .B     (add_b),
      .C_in  (1'b0),
      .S     (sum),
      .C_out (cout)
   );

   always_comb begin
      state_n = state;
      accept  = start && (state == S_IDLE || state == S_DONE);
      zero    = ZERO_SKIP && (A == 16'h0 || B == 16'h0);
      a_mag   = A;
      b_mag   = B;
`ifdef MUL_SIGNED_EN
      sign_n  = SIGNED && (A[15] ^ B[15]);
      if (SIGNED && A[15]) a_mag = ~A + 16'd1;
      if (SIGNED && B[15]) b_mag = ~B + 16'd1;
`endif
      unique case (state)
         S_IDLE, S_DONE: begin
            if (accept)
               state_n = zero ? S_DONE : S_RUN;
            else
               state_n = S_IDLE;
         end
         S_RUN: begin
            if (count == 4'd15) begin
`ifdef MUL_SIGNED_EN
               state_n = smode_q ? S_NEG : S_DONE;
`else
               state_n = S_DONE;
`endif
            end
         end
`ifdef MUL_SIGNED_EN
         S_NEG:   state_n = S_DONE;
`endif
         default: state_n = S_IDLE;
      endcase
`ifdef MUL_SIGNED_EN
      busy_n = (state_n == S_RUN) || (state_n == S_NEG);
`else
      busy_n = (state_n == S_RUN);
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         P       <= 32'h0;
         mcand   <= 16'h0;
         acc_hi  <= 16'h0;
         acc_lo  <= 16'h0;
         count   <= 4'd0;
`ifdef MUL_SIGNED_EN
         neg_q   <= 1'b0;
         smode_q <= 1'b0;
`endif
      end else begin
         state <= state_n;
         busy  <= busy_n;
         done  <= (state == S_DONE);
         if (state == S_DONE)
            P <= prod;
         if (accept) begin
            mcand  <= a_mag;
            acc_hi <= 16'h0;
            // Zero fast path must leave a zero product behind.
            acc_lo <= zero ? 16'h0 : b_mag;
            count  <= 4'd0;
`ifdef MUL_SIGNED_EN
            neg_q   <= sign_n && !zero;
            smode_q <= SIGNED && !zero;
`endif
         end else if (state == S_RUN) begin
            acc_hi <= {cout, sum[15:1]};
            acc_lo <= {sum[0], acc_lo[15:1]};
            count  <= count + 4'd1;
`ifdef MUL_SIGNED_EN
         end else if (state == S_NEG) begin
            if (neg_q)
               {acc_hi, acc_lo} <= ~prod + 32'd1;
`endif
         end
      end
   end

endmodule

// File: tb/tb_mul16_seq.sv
// Scoreboard bench for mul16_seq: default build plus a ZERO_SKIP=0 copy.
// Signed cases are included when MUL_SIGNED_EN is defined.

module tb_mul16_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        sgn;
   logic [15:0] A;
   logic [15:0] B;
   logic        busy;
   logic        done;
   logic [31:0] P;
   logic        busy2;
   logic        done2;
   logic [31:0] P2;

   int n_chk  = 0;
   int n_fail = 0;

   logic [31:0] q_p[$];
   int          q_lat[$];

   always #5 clk = ~clk;

   mul16_seq #(.ZERO_SKIP(1'b1)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
`ifdef MUL_SIGNED_EN
      .SIGNED(sgn),
`endif
      .busy  (busy),
      .done  (done),
      .P     (P)
   );

   mul16_seq #(.ZERO_SKIP(1'b0)) dut_nz (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
`ifdef MUL_SIGNED_EN
      .SIGNED(sgn),
`endif
      .busy  (busy2),
      .done  (done2),
      .P     (P2)
   );

   function automatic logic [31:0] model(input logic [15:0] a,
                                         input logic [15:0] b,
                                         input bit s);
      int sa;
      int sb;
      int r;
      if (s) begin
         sa = int'($signed(a));
         sb = int'($signed(b));
         r  = sa * sb;
         return r;
      end
      return {16'h0, a} * {16'h0, b};
   endfunction

   function automatic int lat_model(input logic [15:0] a,
                                    input logic [15:0] b,
                                    input bit s);
      if (a == 16'h0 || b == 16'h0) return 1;
      if (s) return 18;
      return 17;
   endfunction

   // Call just after a negedge; returns at the negedge after acceptance.
   task automatic issue(input logic [15:0] a, input logic [15:0] b,
                        input bit s);
      A = a;
      B = b;
      sgn = s;
      start = 1'b1;
      q_p.push_back(model(a, b, s));
      q_lat.push_back(lat_model(a, b, s));
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int poke_at, output int lat,
                            output logic [31:0] p, output int bcnt);
      lat  = -1;
      p    = P;
      bcnt = busy ? 1 : 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (busy) bcnt++;
         if (done) begin
            lat = k;
            p = P;
            break;
         end
         if (k == poke_at) begin
            start = 1'b1;
            A = 16'hFFFF;
            B = 16'hFFFF;
         end else if (k == poke_at + 1) begin
            start = 1'b0;
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      start = 1'b0;
      A = 16'h0;
      B = 16'h0;
      sgn = 1'b0;
      repeat (2) @(negedge clk);
      n_chk++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ctl: busy=%b done=%b exp 0 0", busy, done);
      end
      n_chk++;
      if (P !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_p: got %h exp 00000000", P);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_run;
      int seen;
      issue(16'h1234, 16'h5678, 1'b0);
      void'(q_p.pop_front());
      void'(q_lat.pop_front());
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_chk++;
      if (busy !== 1'b0 || done !== 1'b0 || P !== 32'h0) begin
         n_fail++;
         $display("FAIL midrst_state: busy=%b done=%b P=%h exp 0 0 0",
                  busy, done, P);
      end
      rst = 1'b0;
      seen = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (done || done2) seen++;
      end
      n_chk++;
      if (seen !== 0) begin
         n_fail++;
         $display("FAIL midrst_nodone: got %0d pulses exp 0", seen);
      end
   endtask

   task automatic test_basic(input logic [15:0] a, input logic [15:0] b);
      int lat;
      int bc;
      int el;
      logic [31:0] p;
      logic [31:0] ep;
      issue(a, b, 1'b0);
      wait_done(-5, lat, p, bc);
      ep = q_p.pop_front();
      el = q_lat.pop_front();
      n_chk++;
      if (lat !== el) begin
         n_fail++;
         $display("FAIL basic_lat %h*%h: got %0d exp %0d", a, b, lat, el);
      end
      n_chk++;
      if (p !== ep) begin
         n_fail++;
         $display("FAIL basic_p %h*%h: got %h exp %h", a, b, p, ep);
      end
      n_chk++;
      if (bc !== 16) begin
         n_fail++;
         $display("FAIL basic_busy %h*%h: got %0d exp 16", a, b, bc);
      end
      @(negedge clk);
      n_chk++;
      if (done !== 1'b0 || P !== ep) begin
         n_fail++;
         $display("FAIL basic_hold: done=%b P=%h exp 0 %h", done, P, ep);
      end
   endtask

   task automatic test_zero_skip;
      int lat1;
      int lat2;
      int el;
      logic [31:0] p1;
      logic [31:0] p2;
      logic [31:0] ep;
      lat1 = -1;
      lat2 = -1;
      p1 = 32'hX;
      p2 = 32'hX;
      issue(16'h0000, 16'hBEEF, 1'b0);
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (done && lat1 < 0) begin
            lat1 = k;
            p1 = P;
         end
         if (done2 && lat2 < 0) begin
            lat2 = k;
            p2 = P2;
         end
         if (lat1 >= 0 && lat2 >= 0) break;
      end
      ep = q_p.pop_front();
      el = q_lat.pop_front();
      n_chk++;
      if (lat1 !== el || p1 !== ep) begin
         n_fail++;
         $display("FAIL zskip_fast: lat=%0d P=%h exp %0d %h",
                  lat1, p1, el, ep);
      end
      n_chk++;
      if (lat2 !== 17 || p2 !== 32'h0) begin
         n_fail++;
         $display("FAIL zskip_off: lat=%0d P=%h exp 17 00000000",
                  lat2, p2);
      end
      @(negedge clk);
   endtask

   task automatic test_busy_ignore;
      int lat;
      int bc;
      int el;
      logic [31:0] p;
      logic [31:0] ep;
      issue(16'h0007, 16'h0009, 1'b0);
      wait_done(8, lat, p, bc);
      ep = q_p.pop_front();
      el = q_lat.pop_front();
      n_chk++;
      if (lat !== el || p !== ep) begin
         n_fail++;
         $display("FAIL busy_ignore: lat=%0d P=%h exp %0d %h",
                  lat, p, el, ep);
      end
      n_chk++;
      if (P2 !== ep) begin
         n_fail++;
         $display("FAIL busy_ignore_nz: got %h exp %h", P2, ep);
      end
      repeat (3) @(negedge clk);
      n_chk++;
      if (busy !== 1'b0 || P !== ep) begin
         n_fail++;
         $display("FAIL busy_ignore_idle: busy=%b P=%h exp 0 %h",
                  busy, P, ep);
      end
   endtask

   task automatic test_back_to_back;
      int lat;
      int bc;
      int el;
      logic [31:0] p;
      logic [31:0] ep;
      issue(16'h1234, 16'h0002, 1'b0);
      wait_done(-5, lat, p, bc);
      ep = q_p.pop_front();
      el = q_lat.pop_front();
      n_chk++;
      if (lat !== el || p !== ep) begin
         n_fail++;
         $display("FAIL b2b_first: lat=%0d P=%h exp %0d %h",
                  lat, p, el, ep);
      end
      issue(16'h0100, 16'h0100, 1'b0);
      n_chk++;
      if (busy !== 1'b1 || P !== ep) begin
         n_fail++;
         $display("FAIL b2b_accept: busy=%b P=%h exp 1 %h", busy, P, ep);
      end
      wait_done(-5, lat, p, bc);
      ep = q_p.pop_front();
      el = q_lat.pop_front();
      n_chk++;
      if (lat !== el || p !== ep) begin
         n_fail++;
         $display("FAIL b2b_second: lat=%0d P=%h exp %0d %h",
                  lat, p, el, ep);
      end
      @(negedge clk);
   endtask

`ifdef MUL_SIGNED_EN
   task automatic test_signed(input logic [15:0] a, input logic [15:0] b);
      int lat;
      int bc;
      int el;
      logic [31:0] p;
      logic [31:0] ep;
      issue(a, b, 1'b1);
      wait_done(-5, lat, p, bc);
      ep = q_p.pop_front();
      el = q_lat.pop_front();
      n_chk++;
      if (lat !== el || p !== ep) begin
         n_fail++;
         $display("FAIL signed %h*%h: lat=%0d P=%h exp %0d %h",
                  a, b, lat, p, el, ep);
      end
      @(negedge clk);
   endtask
`endif

   initial begin
      test_reset();
      test_reset_mid_run();
      test_basic(16'h0003, 16'h0005);
      test_basic(16'hFFFF, 16'hFFFF);
      test_basic(16'hA5C3, 16'h3C5A);
      test_zero_skip();
      test_busy_ignore();
      test_back_to_back();
`ifdef MUL_SIGNED_EN
      test_signed(16'hFFFD, 16'h0005);
      test_signed(16'h8000, 16'h8000);
      test_signed(16'h7FFF, 16'h8000);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mul16_seq.md
Name: mul16_seq

Overview:
- Multi-cycle 16x16 unsigned shift-and-add multiplier for the 16-bit datapath; 32-bit product.
- Sits around one adder16bit instance: drives its A, B and C_in from internal state each cycle and registers the returned S and C_out.
- Serves the ALU/execute stage as the MUL unit.
- Uses a start/busy/done handshake toward the sequencer.

Parameters:
- ZERO_SKIP, 1: when 1, an accepted start with A==0 or B==0 bypasses RUN and completes in 1 cycle; when 0, all operands take full latency.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- A  input  16  multiplicand; latched on accepted start
- B  input  16  multiplier; latched on accepted start
- busy  output  1  high while in RUN (and NEG if compiled in)
- done  output  1  one-cycle pulse when P becomes valid
- P  output  32  product; held stable from done until the next accepted start

Behaviour:
- Clock and reset: one clock domain, clk. Reset rst is synchronous and active-high. rst wins over all other inputs.
- Reset values: state=IDLE, busy=0, done=0, P=0, count=0, internal registers 0.
- Reset mid-operation: the next edge aborts to IDLE with the reset values. No done pulse is produced.
- State IDLE:
  - start=1: latch mcand=A. Set acc_hi=0, acc_lo=B, count=0.
  - ZERO_SKIP=1 and (A==0 or B==0): go to DONE with P=0.
  - Otherwise go to RUN.
- State RUN (busy=1), one multiplier bit per cycle:
  - Adder inputs: A=acc_hi, B=(acc_lo[0] ? mcand : 16'h0), C_in=0.
  - Next {acc_hi, acc_lo} = {C_out, S, acc_lo} >> 1, i.e. a 33-bit right shift dropping the LSB.
  - count increments. After the cycle where count==15, go to DONE.
- State DONE:
  - P={acc_hi, acc_lo}; done=1 for exactly this cycle; busy=0.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back operation). Otherwise go to IDLE.
- Latency: start accepted at edge 0. done is high in the cycle after edge 17, i.e. 17 cycles from acceptance to result.
  - ZERO_SKIP fast path: done after edge 1.
- start while busy=1 is ignored. There is no queueing.
- A and B changes after acceptance have no effect.
- P holds its last value in IDLE. P is not cleared by a new start until the new DONE.
- Arithmetic: unsigned, exact. The maximum product, 0xFFFF*0xFFFF=0xFFFE0001, fits in 32 bits. No overflow is possible.
- The carry out of each add must be kept (the 33rd bit).
- All outputs are registered. There are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: MUL_SIGNED_EN.
- Defined:
  - Adds input port SIGNED (1 bit), sampled with start.
  - SIGNED=1: A and B are two's complement. The magnitudes |A| and |B| are latched, and the sign=A[15]^B[15] is registered.
  - After RUN, an extra NEG state (busy=1) runs for one cycle. If sign=1, the product is two's-complement negated; otherwise it passes unchanged.
  - SIGNED=1 latency is always 18 cycles. SIGNED=0 stays at 17.
  - -32768 has magnitude 0x8000; it is handled as unsigned 0x8000.
  - The ZERO_SKIP fast path still applies, with P=0 and no NEG.
- Not defined: no SIGNED port, no NEG state; unsigned only.

Test Plan:
- Reset mid-RUN: rst asserted at cycle 5 of A=0x1234, B=0x5678. Next cycle: busy=0, done=0, P=0, state IDLE. No done pulse follows.
- Basic: A=0x0003, B=0x0005 -> done 17 cycles after start, P=0x0000000F. busy high for 16 cycles.
- Max: A=0xFFFF, B=0xFFFF -> P=0xFFFE0001. Exercises C_out retention on every add.
- ZERO_SKIP=1, A=0x0000, B=0xBEEF -> done on the cycle after start, P=0. With ZERO_SKIP=0, the same stimulus completes at 17 cycles with P=0.
- Handshake:
  - start pulsed at cycle 8 while busy -> ignored; result is still for the first operands.
  - start in the DONE cycle with A=0x0100, B=0x0100 -> accepted; second done gives P=0x00010000.
- MUL_SIGNED_EN: SIGNED=1, A=0xFFFD (-3), B=0x0005 -> 18 cycles, P=0xFFFFFFF1. A=0x8000, B=0x8000 -> P=0x40000000.
